// File: rtl/qos_pkg.sv
// Shared constants and types for the weighted round-robin QoS arbiter.
package qos_pkg;
    localparam int QOS_MAX_Q     = 16;
    localparam int QOS_DEF_CNT_W = 8;

    typedef logic [$clog2(QOS_MAX_Q)-1:0] qos_idx_t;
endpackage

// File: rtl/qos_rr_pick.sv
// Combinational rotating priority encoder: first set bit of elig at or after ptr, wrapping.
module qos_rr_pick #(
    parameter int NUM_Q = 4,
    parameter int IDX_W = $clog2(NUM_Q)
) (
    input  logic [NUM_Q-1:0] elig,
    input  logic [IDX_W-1:0] ptr,
    output logic [NUM_Q-1:0] pick,
    output logic [IDX_W-1:0] idx,
    output logic             found
);
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        // First pass covers ptr..NUM_Q-1, second pass the wrapped part 0..ptr-1.
        for (int i = 0; i < NUM_Q; i++) begin
            if (!found && elig[i] && (IDX_W'(i) >= ptr)) begin
                found   = 1'b1;
                pick[i] = 1'b1;
                idx     = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_Q; i++) begin
            if (!found && elig[i] && (IDX_W'(i) < ptr)) begin
                found   = 1'b1;
                pick[i] = 1'b1;
                idx     = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/qos_wrr_arb.sv
// Weighted round-robin QoS arbiter: per-queue credits, work-conserving reload, registered grant.
module qos_wrr_arb
    import qos_pkg::*;
#(
    parameter int NUM_Q      = 4,
    parameter int CNT_W      = QOS_DEF_CNT_W,
    parameter int INTERLEAVE = 1,
    parameter int IDX_W      = $clog2(NUM_Q)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_Q-1:0]       req,
    input  logic [NUM_Q*CNT_W-1:0] weight,
    input  logic                   arb_nxt,
    output logic [NUM_Q-1:0]       gnt,
    output logic                   gnt_vld,
    output logic [IDX_W-1:0]       gnt_idx,
    output logic                   round_start
);
    logic [CNT_W-1:0] credit_q [NUM_Q];
    logic [CNT_W-1:0] credit_d [NUM_Q];
    logic [CNT_W-1:0] wt       [NUM_Q];
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [NUM_Q-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             round_start_q, round_start_d;

    logic [NUM_Q-1:0] elig_live, elig_rld;
    logic [NUM_Q-1:0] live_pick, rld_pick;
    logic [IDX_W-1:0] live_idx, rld_idx;
    logic             live_found, rld_found;

    always_comb begin
        for (int i = 0; i < NUM_Q; i++) begin
            wt[i]        = weight[i*CNT_W +: CNT_W];
            elig_live[i] = req[i] && (credit_q[i] != '0);
            elig_rld[i]  = req[i] && (wt[i] != '0);
        end
    end

    qos_rr_pick #(.NUM_Q(NUM_Q), .IDX_W(IDX_W)) u_pick_live (
        .elig (elig_live),
        .ptr  (ptr_q),
        .pick (live_pick),
        .idx  (live_idx),
        .found(live_found)
    );

    // The reload picker sees the credits as they will be right after reload.
    qos_rr_pick #(.NUM_Q(NUM_Q), .IDX_W(IDX_W)) u_pick_rld (
        .elig (elig_rld),
        .ptr  (ptr_q),
        .pick (rld_pick),
        .idx  (rld_idx),
        .found(rld_found)
    );

    always_comb begin
        gnt_d         = gnt_q;
        gnt_idx_d     = gnt_idx_q;
        ptr_d         = ptr_q;
        credit_d      = credit_q;
        round_start_d = 1'b0;
        if (arb_nxt) begin
            if (live_found) begin
                gnt_d     = live_pick;
                gnt_idx_d = live_idx;
                for (int i = 0; i < NUM_Q; i++) begin
                    if (live_pick[i]) credit_d[i] = credit_q[i] - CNT_W'(1);
                end
            end else if (rld_found) begin
                gnt_d         = rld_pick;
                gnt_idx_d     = rld_idx;
                round_start_d = 1'b1;
                for (int i = 0; i < NUM_Q; i++) begin
                    credit_d[i] = rld_pick[i] ? (wt[i] - CNT_W'(1)) : wt[i];
                end
            end else begin
                gnt_d     = '0;
                gnt_idx_d = '0;
            end
            if (live_found || rld_found) begin
                if (INTERLEAVE != 0) begin
                    ptr_d = (gnt_idx_d == IDX_W'(NUM_Q-1)) ? '0 : gnt_idx_d + 1'b1;
                end else begin
                    ptr_d = gnt_idx_d;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q         <= '0;
            gnt_idx_q     <= '0;
            ptr_q         <= '0;
            round_start_q <= 1'b0;
            for (int i = 0; i < NUM_Q; i++) credit_q[i] <= '0;
        end else begin
            gnt_q         <= gnt_d;
            gnt_idx_q     <= gnt_idx_d;
            ptr_q         <= ptr_d;
            round_start_q <= round_start_d;
            credit_q      <= credit_d;
        end
    end

    assign gnt         = gnt_q;
    assign gnt_vld     = |gnt_q;
    assign gnt_idx     = gnt_idx_q;
    assign round_start = round_start_q;
endmodule
